// File: rtl/pmul_ladder_seq.sv
// pmul_ladder_seq: constant-schedule Montgomery-ladder sequencer for the ECC point-multiply core (PMUL_LADDER_SEQ_LZSKIP_EN skips leading zero scalar bits)
module pmul_ladder_seq #(
  parameter int pKEY_WIDTH = 256,
  parameter int pWORDS     = pKEY_WIDTH/32,
  parameter int pAW        = 3
) (
  input  logic           crypto_clk,
  input  logic           reset_n,
  input  logic           I_start,
  output logic [pAW-1:0] O_k_addr,
  input  logic [31:0]    I_k_word,
  output logic           O_op_valid,
  output logic [1:0]     O_op_code,
  output logic           O_op_swap,
  input  logic           I_op_ready,
  input  logic           I_op_done,
  output logic [pAW-1:0] O_res_addr,
  input  logic [31:0]    I_res_x,
  input  logic [31:0]    I_res_y,
  output logic [pAW-1:0] O_r_addr,
  output logic           O_r_wren,
  output logic [31:0]    O_rx_word,
  output logic [31:0]    O_ry_word,
  output logic           O_ready,
  output logic           O_busy,
  output logic           O_done
);
  localparam int BW = $clog2(pKEY_WIDTH);
  localparam logic [pAW:0] LAST = pWORDS;
`ifdef PMUL_LADDER_SEQ_LZSKIP_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  typedef enum logic [3:0] {S_IDLE, S_LOAD, S_FETCH, S_ADD, S_DOUBLE, S_NEXT, S_CONV, S_COPY, S_DONE} state_t;
  state_t state, state_nxt;
  logic wait_ph, seen, op_st, done_ev, skip_f, skip_n;
  logic [BW-1:0] bit_idx, idx_dec;
  logic [31:0] kw;
  logic [pAW:0] cnt;
  assign op_st   = state inside {S_LOAD, S_ADD, S_DOUBLE, S_CONV};
  assign done_ev = wait_ph && I_op_done;
  assign idx_dec = bit_idx - 1'b1;
  assign skip_f  = LZ && !seen && !I_k_word[bit_idx[4:0]];
  assign skip_n  = LZ && !seen && !kw[idx_dec[4:0]];
  always_ff @(posedge crypto_clk or negedge reset_n)
    if (!reset_n) begin
      state   <= S_IDLE;
      wait_ph <= 1'b0;
    end else begin
      state   <= state_nxt;
      wait_ph <= op_st && (wait_ph ? !I_op_done : I_op_ready);
    end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = I_start ? S_LOAD : S_IDLE;
      S_LOAD:   state_nxt = done_ev ? S_FETCH : S_LOAD;
      S_FETCH:  state_nxt = skip_f ? S_NEXT : S_ADD;
      S_ADD:    state_nxt = done_ev ? S_DOUBLE : S_ADD;
      S_DOUBLE: state_nxt = done_ev ? S_NEXT : S_DOUBLE;
      S_NEXT:   state_nxt = bit_idx == '0 ? S_CONV : bit_idx[4:0] == 5'd0 ? S_FETCH : skip_n ? S_NEXT : S_ADD;
      S_CONV:   state_nxt = done_ev ? S_COPY : S_CONV;
      S_COPY:   state_nxt = cnt == LAST ? S_DONE : S_COPY;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge crypto_clk or negedge reset_n)
    if (!reset_n) begin
      bit_idx  <= '0;
      kw       <= '0;
      cnt      <= '0;
      seen     <= 1'b0;
      O_r_wren <= 1'b0;
      O_r_addr <= '0;
    end else begin
      if (state == S_IDLE && I_start) begin
        bit_idx <= BW'(pKEY_WIDTH-1);
        seen    <= 1'b0;
      end
      if (state == S_NEXT && bit_idx != '0) bit_idx <= idx_dec;
      if (state == S_FETCH) kw <= I_k_word;
      if (state_nxt == S_ADD) seen <= 1'b1;
      cnt      <= state == S_COPY ? cnt + 1'b1 : '0;
      O_r_wren <= state == S_COPY && cnt < LAST;
      O_r_addr <= state == S_COPY ? cnt[pAW-1:0] : '0;
    end
  always_comb begin
    O_ready    = state == S_IDLE;
    O_busy     = state != S_IDLE;
    O_done     = state == S_DONE;
    O_op_valid = op_st && !wait_ph;
    O_op_code  = state == S_ADD ? 2'b01 : state == S_DOUBLE ? 2'b10 : state == S_CONV ? 2'b11 : 2'b00;
    O_op_swap  = (state == S_ADD || state == S_DOUBLE) && kw[bit_idx[4:0]];
    O_k_addr   = bit_idx[pAW+4:5];
    O_res_addr = state == S_COPY ? cnt[pAW-1:0] : '0;
    O_rx_word  = O_r_wren ? I_res_x : '0;
    O_ry_word  = O_r_wren ? I_res_y : '0;
  end
endmodule

// File: tb/tb_pmul_ladder_seq.sv
// tb_pmul_ladder_seq: scoreboard bench driving the ladder sequencer with a scripted point-arithmetic core
`timescale 1ns/1ps
module tb_pmul_ladder_seq;
  logic crypto_clk = 1'b0, reset_n = 1'b0, I_start = 1'b0;
  logic [2:0] O_k_addr, O_res_addr, O_r_addr;
  logic [31:0] I_k_word, I_res_x = '0, I_res_y = '0, O_rx_word, O_ry_word;
  logic O_op_valid, O_op_swap, O_r_wren, O_ready, O_busy, O_done;
  logic I_op_ready = 1'b1, I_op_done = 1'b0;
  logic [1:0] O_op_code;
  logic [255:0] kreg = '0;
  logic [2:0] opq[$];
  logic [66:0] wq[$];
  logic [2:0] held = '0;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_done = 0, busy = 0, stall = 0;
  bit stall_arm = 1'b0, inj_done = 1'b0;
  localparam logic [80:0] RST = {1'b1, 80'd0};
  wire [80:0] outs = {O_ready, O_busy, O_done, O_op_valid, O_op_code, O_op_swap, O_k_addr,
                      O_res_addr, O_r_addr, O_r_wren, O_rx_word, O_ry_word};

  pmul_ladder_seq dut (
    .crypto_clk(crypto_clk), .reset_n(reset_n), .I_start(I_start),
    .O_k_addr(O_k_addr), .I_k_word(I_k_word),
    .O_op_valid(O_op_valid), .O_op_code(O_op_code), .O_op_swap(O_op_swap),
    .I_op_ready(I_op_ready), .I_op_done(I_op_done),
    .O_res_addr(O_res_addr), .I_res_x(I_res_x), .I_res_y(I_res_y),
    .O_r_addr(O_r_addr), .O_r_wren(O_r_wren), .O_rx_word(O_rx_word), .O_ry_word(O_ry_word),
    .O_ready(O_ready), .O_busy(O_busy), .O_done(O_done)
  );

  always #5 crypto_clk = ~crypto_clk;
  assign I_k_word = kreg[{O_k_addr, 5'd0} +: 32];

  // result RAM of the core: one-cycle read latency
  always @(posedge crypto_clk) begin
    I_res_x <= 32'hC0DE_0000 + 32'(O_res_addr);
    I_res_y <= 32'h5EED_0000 + 32'(O_res_addr) * 32'd3;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // core model and monitor: accepts ops, pulses done 4 cycles later, scoreboards ops and copy writes
  always @(negedge crypto_clk) begin
    I_op_done = 1'b0;
    if (busy > 0) begin
      busy--;
      I_op_done = busy == 0;
    end
    I_op_ready = 1'b1;
    if (stall > 0) begin
      I_op_ready = 1'b0;
      stall--;
      chk("stall_hold", {O_op_valid, O_op_code, O_op_swap}, {1'b1, held});
    end else if (O_op_valid && stall_arm && O_op_code == 2'b01) begin
      stall_arm = 1'b0;
      stall = 9;
      held = {O_op_code, O_op_swap};
      I_op_ready = 1'b0;
    end else if (O_op_valid) begin
      n_acc++;
      busy = 4;
      if (inj_done) begin
        I_op_done = 1'b1;
        inj_done = 1'b0;
      end
      if (opq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL op_extra: got op %0h, expected no op", {O_op_code, O_op_swap});
      end else chk("op_seq", {O_op_code, O_op_swap}, opq.pop_front());
    end
    if (O_r_wren) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL copy_extra: got write addr %0d, expected none", O_r_addr);
      end else chk("copy_write", {O_r_addr, O_rx_word, O_ry_word}, wq.pop_front());
    end
    if (O_done) begin
      n_done++;
      chk("done_queues_empty", opq.size() + wq.size(), 0);
    end
  end

  task automatic push_exp(input logic [255:0] k);
    int top;
    opq.delete();
    wq.delete();
    opq.push_back(3'b000);
`ifdef PMUL_LADDER_SEQ_LZSKIP_EN
    top = -1;
    for (int b = 255; b >= 0; b--) if (k[b] && top < 0) top = b;
`else
    top = 255;
`endif
    for (int b = top; b >= 0; b--) begin
      opq.push_back({2'b01, k[b]});
      opq.push_back({2'b10, k[b]});
    end
    opq.push_back(3'b110);
    for (int a = 0; a < 8; a++) wq.push_back({3'(a), 32'hC0DE_0000 + 32'(a), 32'h5EED_0000 + 32'(3 * a)});
  endtask

  task automatic launch(input string nm, input logic [255:0] k);
    kreg = k;
    push_exp(k);
    n_acc = 0;
    n_done = 0;
    @(negedge crypto_clk);
    I_start = 1'b1;
    @(negedge crypto_clk);
    I_start = 1'b0;
    chk({nm, "_launch"}, {O_busy, O_ready, O_op_valid, O_op_code}, 5'b10100);
  endtask

  task automatic run(input string nm, input logic [255:0] k, input int exp_cyc, input int exp_ops,
                     input bit glitch, input bit stall_en);
    int n;
    stall_arm = stall_en;
    launch(nm, k);
    n = 1;
    while (!O_done && n < 20000) begin
      @(negedge crypto_clk);
      n++;
      I_start = glitch && n == 500;
      if (glitch && n == 600) inj_done = 1'b1;
    end
    I_start = 1'b0;
    chk({nm, "_cycles"}, n, exp_cyc);
    @(negedge crypto_clk);
    chk({nm, "_ops"}, n_acc, exp_ops);
    chk({nm, "_done_once"}, n_done, 1);
    chk({nm, "_idle"}, {O_ready, O_busy, O_done, O_r_wren}, 4'b1000);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge crypto_clk);
    chk("reset_state", outs, RST);
    reset_n = 1'b1;
    @(negedge crypto_clk);
    chk("idle_after_reset", outs, RST);
`ifdef PMUL_LADDER_SEQ_LZSKIP_EN
    run("lz_k5", 256'd5, 314, 8, 1'b0, 1'b0);
    run("lz_k0", 256'd0, 284, 2, 1'b0, 1'b0);
    run("lz_k1", 256'd1, 294, 4, 1'b0, 1'b0);
`else
    run("k1", 256'd1, 2844, 514, 1'b1, 1'b0);
    run("kff", {256{1'b1}}, 2844, 514, 1'b0, 1'b0);
    run("stall", 256'd1, 2854, 514, 1'b0, 1'b1);
    launch("rst", 256'd1);
    n = 0;
    while (n_acc < 313 && n < 5000) begin
      @(negedge crypto_clk);
      n++;
    end
    chk("rst_reach_double_bit100", n_acc, 313);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outputs", outs, RST);
    @(negedge crypto_clk);
    #2 reset_n = 1'b1;
    opq.delete();
    wq.delete();
    repeat (8) begin
      @(negedge crypto_clk);
      chk("rst_stays_idle", {O_ready, O_busy, O_op_valid, O_r_wren}, 4'b1000);
    end
    run("k1_after_rst", 256'd1, 2844, 514, 1'b0, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
